// File: rtl/phase_timer_regs.sv
// Programmable phase-duration register file with a cyclic countdown sequencer.
// Host reads/writes durations over the cs/w_r/addr bus; the sequencer walks the phases on tick.
module phase_timer_regs #(
    parameter int unsigned NPH     = 3,
    parameter int unsigned AW      = 2,
    parameter int unsigned DW      = 6,
    parameter int unsigned DEF_DUR = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          w_r,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] r_data,
    input  logic          run,
    input  logic          tick,
    output logic [AW-1:0] phase,
    output logic [DW-1:0] remain,
    output logic          phase_done,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_PH = AW'(NPH - 1);
    localparam logic [DW-1:0] DEF_VAL = DW'(DEF_DUR);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] phase_q, phase_d;
    logic [DW-1:0] remain_q, remain_d;
    logic          done_q, done_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] dur_q [NPH];

    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] ph_dur;

    assign wr_en = !cs && w_r;
    assign rd_en = !cs && !w_r;

    // Out-of-range addresses match no entry, so they read as 0 and write nothing.
    always_comb begin
        rd_val = '0;
        ph_dur = '0;
        for (int unsigned i = 0; i < NPH; i++) begin
            if (addr == AW'(i)) begin
                rd_val = dur_q[i];
            end
            if (phase_q == AW'(i)) begin
                ph_dur = dur_q[i];
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            for (int unsigned i = 0; i < NPH; i++) begin
                dur_q[i] <= DEF_VAL;
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            if (rd_en) begin
                rdata_q <= rd_val;
            end
            for (int unsigned i = 0; i < NPH; i++) begin
                if (wr_en && (addr == AW'(i))) begin
                    dur_q[i] <= w_data;
                end
            end
        end
    end

    // Next-state logic; run low forces IDLE ahead of any tick.
    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = LOAD;
                LOAD:    state_d = COUNT;
                COUNT:   if (tick && (remain_q <= DW'(1))) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        if (!run) begin
            phase_d  = '0;
            remain_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    phase_d  = '0;
                    remain_d = '0;
                end
                LOAD: begin
                    remain_d = (ph_dur == '0) ? DW'(1) : ph_dur;
                end
                COUNT: begin
                    if (tick) begin
                        if (remain_q <= DW'(1)) begin
                            done_d   = 1'b1;
                            phase_d  = (phase_q == LAST_PH) ? '0 : phase_q + AW'(1);
                            remain_d = '0;
                        end else begin
                            remain_d = remain_q - DW'(1);
                        end
                    end
                end
                default: begin
                    phase_d  = '0;
                    remain_d = '0;
                end
            endcase
        end
    end

    assign r_data     = rdata_q;
    assign phase      = phase_q;
    assign remain     = remain_q;
    assign phase_done = done_q;
    assign busy       = (state_q != IDLE);

endmodule
